sw_step_reader: RTL and testbench
=================================

Name: sw_step_reader

Overview:
- Input-side front end for the up/down LED counter.
- Takes two raw, asynchronous push-button inputs, `btn_up` and `btn_dn`, and synchronizes and debounces each one.
- Converts each clean press into a single-cycle step pulse that drives the counter's increment/decrement enable.
- Also exports the debounced button levels for status display.

Parameters:
- DEB_CYCLES, 16, consecutive stable cycles required to accept a level change. Minimum 2. Board build uses 500000.
- REP_DELAY, 64, cycles a press must be held before the first auto-repeat pulse. Used only with AUTO_REPEAT_EN.
- REP_PERIOD, 16, cycles between subsequent auto-repeat pulses. Used only with AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  synchronous, active-low reset
- btn_up  input  1  raw asynchronous up button, active high
- btn_dn  input  1  raw asynchronous down button, active high
- step_up  output  1  one-cycle pulse requesting +1
- step_dn  output  1  one-cycle pulse requesting -1
- up_level  output  1  debounced btn_up level
- dn_level  output  1  debounced btn_dn level

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. All flops update only on posedge clk; rst_n is sampled like any other input.
- Reset values: all outputs 0; sync flops 0; debounce counters 0; FSMs in IDLE.
- Synchronizer: each raw input passes through a 2-flop synchronizer. Downstream logic sees only the second flop (`sync`).
- Debounce FSM, one per button. States:
  - IDLE: stable low.
  - CHK_PRESS
  - PRESSED: stable high.
  - CHK_REL
- Transitions:
  - IDLE -> CHK_PRESS when sync=1.
  - CHK_PRESS -> IDLE if sync=0 (counter cleared).
  - CHK_PRESS -> PRESSED when counter reaches DEB_CYCLES-1 with sync still 1.
  - PRESSED -> CHK_REL when sync=0.
  - CHK_REL -> PRESSED if sync=1 (counter cleared).
  - CHK_REL -> IDLE at DEB_CYCLES-1.
- Counter: width `$clog2(DEB_CYCLES)`. Increments once per cycle in a CHK state and saturates; it never wraps. It clears on every state change.
- Level outputs: `level` = 1 in PRESSED and CHK_REL, 0 otherwise.
- Press pulse: an internal one-cycle pulse on each CHK_PRESS -> PRESSED transition. No pulse is generated on release.
- Latency: raw input rises and is held. With the first sampling edge as edge k, the pulse is high during the cycle after edge k+1+DEB_CYCLES.
- Glitch rejection: any bounce shorter than DEB_CYCLES consecutive cycles produces no level change and no pulse.
- Registered outputs:
  - step_up = up press pulse AND NOT dn press pulse in the same cycle.
  - step_dn is symmetric.
  - Simultaneous press pulses cancel: neither step is issued.
- Holding a button: no further pulses without AUTO_REPEAT_EN.
- Holding one button while the other is pressed: the second button still steps normally.
- Reset mid-debounce: any pending press is discarded. After reset, a button that is still held must re-qualify for a full DEB_CYCLES before it steps.
- Outputs are never X after the first reset cycle.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- When defined:
  - A per-button repeat counter runs while in PRESSED.
  - The first repeat pulse comes REP_DELAY cycles after the press pulse.
  - Further repeats follow every REP_PERIOD cycles.
  - The repeat counter clears on leaving PRESSED. CHK_REL pauses and holds it.
  - Repeat pulses share the same cancellation rule as press pulses.
- When undefined: no repeat logic is synthesized; exactly one pulse is issued per press.

Decomposition:
- Shared package/include:
  - FSM state encodings: IDLE=2'd0, CHK_PRESS=2'd1, PRESSED=2'd2, CHK_REL=2'd3.
  - Default DEB_CYCLES/REP_DELAY/REP_PERIOD constants.
- Sub-module btn_debounce: synchronizer, FSM, counter and optional repeat logic for one button. It outputs `level` and `pulse`.
- Top level: instantiates btn_debounce twice and adds the cancellation and output registers.

Test Plan (DEB_CYCLES=4, REP_DELAY=8, REP_PERIOD=3):
- Reset: hold rst_n=0 for 3 cycles with btn_up=1 -> all outputs 0. Release rst_n -> exactly one step_up pulse after 2+4 cycles; up_level=1.
- Bounce: toggle btn_up 1,0,1,1,0 cycle-by-cycle, then hold 1 for 6 cycles -> no pulse during bouncing; exactly one step_up pulse 6 cycles after the final rise.
- Release debounce: hold btn_dn for 10 cycles, then drop it to 0 for 2 cycles and back to 1 -> dn_level stays 1; single step_dn total.
- Simultaneous: assert btn_up and btn_dn on the same edge and hold both -> up_level=dn_level=1; step_up=step_dn=0 throughout.
- Staggered: btn_up at cycle 0, btn_dn at cycle 2 -> step_up at cycle 6, step_dn at cycle 8; each is exactly one cycle wide.
- AUTO_REPEAT_EN: hold btn_up for 30 cycles -> pulses at cycles 6, 14, 17, 20, 23, 26, 29. Without the macro, only the pulse at 6.

Source files
------------

// File: rtl/sw_step_reader_pkg.sv
// sw_step_reader_pkg
// Shared definitions for the push-button front end of the up/down LED counter.
// Contents:
//   deb_state_e      - debounce FSM state encoding (also exported for debug)
//   *_DEF constants  - default DEB_CYCLES / REP_DELAY / REP_PERIOD values
// Optional feature macro used by the design: AUTO_REPEAT_EN.
package sw_step_reader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,   // stable low
        CHK_PRESS = 2'd1,   // input went high, qualifying
        PRESSED   = 2'd2,   // stable high
        CHK_REL   = 2'd3    // input went low, qualifying
    } deb_state_e;

    localparam int DEB_CYCLES_DEF = 16;
    localparam int REP_DELAY_DEF  = 64;
    localparam int REP_PERIOD_DEF = 16;

endpackage

// File: rtl/sw_step_reader_if.sv
// sw_step_reader_if
// Bundles the button inputs, step/level outputs and the per-button debounce
// FSM states of sw_step_reader.
// Modports:
//   master - environment side: drives btn_up/btn_dn, observes everything else
//   slave  - sw_step_reader side
// Signalling: btn_up/btn_dn are raw asynchronous levels (active high).
// step_up/step_dn are single-cycle pulses; each high cycle is exactly one
// +1/-1 request, there is no back-pressure. up_level/dn_level are the
// debounced levels. up_state/dn_state expose the debounce FSMs for debug.
interface sw_step_reader_if;
    import sw_step_reader_pkg::*;

    logic       btn_up;
    logic       btn_dn;
    logic       step_up;
    logic       step_dn;
    logic       up_level;
    logic       dn_level;
    deb_state_e up_state;
    deb_state_e dn_state;

    modport master (
        output btn_up, btn_dn,
        input  step_up, step_dn, up_level, dn_level, up_state, dn_state
    );

    modport slave (
        input  btn_up, btn_dn,
        output step_up, step_dn, up_level, dn_level, up_state, dn_state
    );

endinterface

// File: rtl/sw_step_reader_btn_debounce.sv
// btn_debounce
// One-button front end: 2-flop synchronizer, 4-state debounce FSM with a
// saturating qualification counter, and a registered press pulse.
// With AUTO_REPEAT_EN defined, a repeat counter adds pulses while the
// button is held (first after REP_DELAY cycles, then every REP_PERIOD).
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   btn         - raw asynchronous button input
//   level       - debounced level (high in PRESSED and CHK_REL)
//   pulse       - one-cycle pulse per accepted press (and per repeat)
//   dbg_state   - current FSM state
module btn_debounce
    import sw_step_reader_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int REP_DELAY  = REP_DELAY_DEF,
    parameter int REP_PERIOD = REP_PERIOD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    output logic       level,
    output logic       pulse,
    output deb_state_e dbg_state
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 2 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_param_check
        $error("btn_debounce: DEB_CYCLES must be >= 2, REP_DELAY/REP_PERIOD >= 1");
    end

    logic             sync_meta;
    logic             sync;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             press_d;
    logic             pulse_q, pulse_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync      <= sync_meta;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // The sample that moves IDLE->CHK_PRESS counts as the first stable one,
    // so the change is accepted when the incremented count hits DEB_CYCLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sync) state_d = CHK_PRESS;
            end
            CHK_PRESS: begin
                if (!sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (!sync) state_d = CHK_REL;
            end
            CHK_REL: begin
                if (sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX) + 1;

    logic [REP_W-1:0] rep_q, rep_d, rep_target;
    logic             first_q, first_d;
    logic             rep_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_q   <= '0;
            first_q <= 1'b1;
        end else begin
            rep_q   <= rep_d;
            first_q <= first_d;
        end
    end

    // Counts only while staying in PRESSED; a release bounce (CHK_REL)
    // freezes it so a recovered hold keeps its repeat cadence.
    always_comb begin
        rep_d      = rep_q;
        first_d    = first_q;
        rep_fire   = 1'b0;
        rep_target = first_q ? REP_W'(REP_DELAY - 1) : REP_W'(REP_PERIOD - 1);
        case (state_q)
            PRESSED: begin
                if (sync) begin
                    if (rep_q == rep_target) begin
                        rep_fire = 1'b1;
                        rep_d    = '0;
                        first_d  = 1'b0;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
                end
            end
            CHK_REL: begin
                rep_d   = rep_q;
                first_d = first_q;
            end
            default: begin
                rep_d   = '0;
                first_d = 1'b1;
            end
        endcase
    end

    assign pulse_d = press_d | rep_fire;
`else
    assign pulse_d = press_d;
`endif

    assign level     = (state_q == PRESSED) || (state_q == CHK_REL);
    assign pulse     = pulse_q;
    assign dbg_state = state_q;

endmodule

// File: rtl/sw_step_reader.sv
// sw_step_reader
// Input front end for the up/down LED counter: debounces btn_up/btn_dn and
// turns each clean press into a one-cycle step_up/step_dn pulse. Press (and,
// with AUTO_REPEAT_EN, repeat) pulses arriving in the same cycle cancel.
// Ports:
//   clk    - system clock
//   rst_n  - synchronous active-low reset
//   bus    - sw_step_reader_if.slave: btn_up/btn_dn in; step_up, step_dn,
//            up_level, dn_level, up_state, dn_state out
// Optional feature macro: AUTO_REPEAT_EN (auto-repeat while a button is held).
module sw_step_reader
    import sw_step_reader_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int REP_DELAY  = REP_DELAY_DEF,
    parameter int REP_PERIOD = REP_PERIOD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    sw_step_reader_if.slave   bus
);

    logic       up_pulse, dn_pulse;
    logic       up_level, dn_level;
    deb_state_e up_state, dn_state;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
    ) u_up (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (bus.btn_up),
        .level    (up_level),
        .pulse    (up_pulse),
        .dbg_state(up_state)
    );

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
    ) u_dn (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (bus.btn_dn),
        .level    (dn_level),
        .pulse    (dn_pulse),
        .dbg_state(dn_state)
    );

    // Opposite requests in the same cycle would net to zero; drop both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.step_up <= 1'b0;
            bus.step_dn <= 1'b0;
        end else begin
            bus.step_up <= up_pulse & ~dn_pulse;
            bus.step_dn <= dn_pulse & ~up_pulse;
        end
    end

    assign bus.up_level = up_level;
    assign bus.dn_level = dn_level;
    assign bus.up_state = up_state;
    assign bus.dn_state = dn_state;

endmodule

// File: tb/tb_sw_step_reader.sv
// tb_sw_step_reader
// Directed bench for sw_step_reader with DEB_CYCLES=4, REP_DELAY=8,
// REP_PERIOD=3. Cycle c of a scenario is the interval after clock edge c;
// inputs for edge c are applied before it. Each cycle compares the vector
// {step_up, step_dn, up_level, dn_level} with a hand-derived expectation.
// Builds with or without AUTO_REPEAT_EN.
module tb_sw_step_reader;
    import sw_step_reader_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    sw_step_reader_if bus();

    sw_step_reader #(
        .DEB_CYCLES(4),
        .REP_DELAY (8),
        .REP_PERIOD(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] observed();
        return {bus.step_up, bus.step_dn, bus.up_level, bus.dn_level};
    endfunction

    // release both buttons and let everything settle back to IDLE
    task automatic go_idle();
        logic [3:0] obs;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        repeat (12) tick();
        obs = observed();
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle: got %b expected 0000", obs);
        end
    endtask

    task automatic test_reset();
        logic [3:0] obs, exp;
        rst_n      = 1'b0;
        bus.btn_up = 1'b1;
        bus.btn_dn = 1'b0;
        repeat (3) tick();
        obs = observed();
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000", obs);
        end
        n_checks++;
        if ({bus.up_state, bus.dn_state} !== {IDLE, IDLE}) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 0000", {bus.up_state, bus.dn_state});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            exp = {(c == 6), 1'b0, (c >= 5), 1'b0};
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_release cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] obs, exp;
        logic       pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 16; c++) begin
            bus.btn_up = (c < 5) ? pat[c] : 1'b1;
            tick();
            exp = {(c == 11), 1'b0, (c >= 10), 1'b0};
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL bounce cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic [3:0] obs, exp;
        for (int c = 0; c < 20; c++) begin
            bus.btn_dn = (c < 10 || c >= 12);
            tick();
            exp = {1'b0, (c == 6), 1'b0, (c >= 5)};
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL release_bounce cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] obs, exp;
        for (int c = 0; c < 14; c++) begin
            bus.btn_up = 1'b1;
            bus.btn_dn = 1'b1;
            tick();
            exp = {1'b0, 1'b0, (c >= 5), (c >= 5)};
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL simultaneous cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_staggered();
        logic [3:0] obs, exp;
        for (int c = 0; c < 14; c++) begin
            bus.btn_up = 1'b1;
            bus.btn_dn = (c >= 2);
            tick();
            exp = {(c == 6), (c == 8), (c >= 5), (c >= 7)};
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL staggered cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_hold();
        logic [3:0] obs, exp;
        logic       step_exp;
        for (int c = 0; c < 30; c++) begin
            bus.btn_up = 1'b1;
            tick();
`ifdef AUTO_REPEAT_EN
            step_exp = (c == 6) || (c >= 14 && ((c - 14) % 3) == 0);
`else
            step_exp = (c == 6);
`endif
            exp = {step_exp, 1'b0, (c >= 5), 1'b0};
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL hold cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [3:0] obs, exp;
        for (int c = 0; c < 14; c++) begin
            bus.btn_up = 1'b1;
            rst_n      = (c != 3);
            tick();
            exp = {(c == 10), 1'b0, (c >= 9), 1'b0};
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        test_reset();
        go_idle();
        test_bounce();
        go_idle();
        test_release_bounce();
        go_idle();
        test_simultaneous();
        go_idle();
        test_staggered();
        go_idle();
        test_hold();
        go_idle();
        test_reset_mid_debounce();
        go_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
